// File: rtl/dmem_responder_if.sv
// Signal bundle between the processor's Dmem port / host backdoor and dmem_responder.
// The slave modport belongs to the responder; master is the processor/host side.
interface dmem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    logic              DmemEn;
    logic              DmemWrEn;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Data_Out;
    logic [DATA_W-1:0] Data_In;
    logic              Host_Req;
    logic              Host_WrEn;
    logic [ADDR_W-1:0] Host_Addr;
    logic [DATA_W-1:0] Host_WrData;
    logic              Host_Ack;
    logic [DATA_W-1:0] Host_RdData;
    logic              Init_Done;
    logic [CNT_W-1:0]  Rd_Count;
    logic [CNT_W-1:0]  Wr_Count;

    modport slave (
        input  DmemEn, DmemWrEn, Mem_Addr, Data_Out,
        input  Host_Req, Host_WrEn, Host_Addr, Host_WrData,
        output Data_In, Host_Ack, Host_RdData, Init_Done, Rd_Count, Wr_Count
    );

    modport master (
        output DmemEn, DmemWrEn, Mem_Addr, Data_Out,
        output Host_Req, Host_WrEn, Host_Addr, Host_WrData,
        input  Data_In, Host_Ack, Host_RdData, Init_Done, Rd_Count, Wr_Count
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: 1-cycle synchronous-read word RAM for the processor's Dmem port,
// with a host backdoor, an optional post-reset clear sweep and saturating access counters.
module dmem_responder #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 64,
    parameter int DEPTH          = 256,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic Clock,
    input  logic Reset,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {INIT, IDLE, HOST_RD} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              init_done_reg, init_done_next;
    logic              ack_reg, ack_next;
    logic [DATA_W-1:0] data_in_reg;
    logic [DATA_W-1:0] host_rd_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rd, cpu_wr, host_rd;

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        init_done_next = init_done_reg;
        ack_next       = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = ptr_reg;
        mem_wdata      = '0;
        cpu_rd         = 1'b0;
        cpu_wr         = 1'b0;
        host_rd        = 1'b0;
        case (state_reg)
            INIT: begin
                mem_we   = 1'b1;
                ptr_next = ptr_reg + ADDR_W'(1);
                if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next     = IDLE;
                    init_done_next = 1'b1;
                end
            end
            IDLE, HOST_RD: begin
                cpu_rd = bus.DmemEn && !bus.DmemWrEn;
                cpu_wr = bus.DmemEn && bus.DmemWrEn;
                if (state_reg == HOST_RD) begin
                    state_next = IDLE;
                // The ack cycle itself never starts a new host access: Host_Req may still be high there.
                end else if (bus.Host_Req && !bus.DmemEn && !ack_reg) begin
                    ack_next = 1'b1;
                    if (bus.Host_WrEn) begin
                        mem_we    = 1'b1;
                        mem_waddr = bus.Host_Addr;
                        mem_wdata = bus.Host_WrData;
                    end else begin
                        host_rd    = 1'b1;
                        state_next = HOST_RD;
                    end
                end
                if (cpu_wr) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.Mem_Addr;
                    mem_wdata = bus.Data_Out;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg     <= CLEAR_ON_RESET ? INIT : IDLE;
            ptr_reg       <= '0;
            init_done_reg <= !CLEAR_ON_RESET;
            ack_reg       <= 1'b0;
            data_in_reg   <= '0;
            host_rd_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            init_done_reg <= init_done_next;
            ack_reg       <= ack_next;
            if (cpu_rd) begin
                data_in_reg <= mem[bus.Mem_Addr];
            end
            if (host_rd) begin
                host_rd_reg <= mem[bus.Host_Addr];
            end
        end
    end

    // Storage has no reset; writes are suppressed while Reset is high so an aborted access leaves no trace.
    always_ff @(posedge Clock) begin
        if (mem_we && !Reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [1:0]         cnt_inc;
    logic [2*CNT_W-1:0] cnt_flat;
    assign cnt_inc = {cpu_wr, cpu_rd};

    for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
        logic [CNT_W-1:0] count_reg;
        always_ff @(posedge Clock) begin
            if (Reset) begin
                count_reg <= '0;
            end else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
        assign cnt_flat[gi*CNT_W +: CNT_W] = count_reg;
    end

    assign bus.Data_In     = data_in_reg;
    assign bus.Host_Ack    = ack_reg;
    assign bus.Host_RdData = host_rd_reg;
    assign bus.Init_Done   = init_done_reg;
    assign bus.Rd_Count    = cnt_flat[0 +: CNT_W];
    assign bus.Wr_Count    = cnt_flat[CNT_W +: CNT_W];
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a full-size instance plus a tiny no-clear instance for counter saturation.
`timescale 1ns/1ps
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(8), .DATA_W(64), .CNT_W(16)) bus ();
    dmem_responder_if #(.ADDR_W(4), .DATA_W(8),  .CNT_W(2))  sbus ();

    dmem_responder #(.ADDR_W(8), .DATA_W(64), .DEPTH(256), .CLEAR_ON_RESET(1'b1), .CNT_W(16)) dut (
        .Clock(clk), .Reset(rst), .bus(bus.slave)
    );
    dmem_responder #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .CLEAR_ON_RESET(1'b0), .CNT_W(2)) sdut (
        .Clock(clk), .Reset(rst), .bus(sbus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.DmemEn = 0; bus.DmemWrEn = 0; bus.Mem_Addr = '0; bus.Data_Out = '0;
        bus.Host_Req = 0; bus.Host_WrEn = 0; bus.Host_Addr = '0; bus.Host_WrData = '0;
        sbus.DmemEn = 0; sbus.DmemWrEn = 0; sbus.Mem_Addr = '0; sbus.Data_Out = '0;
        sbus.Host_Req = 0; sbus.Host_WrEn = 0; sbus.Host_Addr = '0; sbus.Host_WrData = '0;
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [63:0] data);
        bus.DmemEn = 1; bus.DmemWrEn = 1; bus.Mem_Addr = addr; bus.Data_Out = data;
        step();
        bus.DmemEn = 0; bus.DmemWrEn = 0;
        $display("cpu write addr=%02h data=%016h", addr, data);
    endtask

    task automatic cpu_read(input logic [7:0] addr, output logic [63:0] data);
        bus.DmemEn = 1; bus.DmemWrEn = 0; bus.Mem_Addr = addr;
        step();
        data = bus.Data_In;
        bus.DmemEn = 0;
        $display("cpu read  addr=%02h data=%016h", addr, data);
    endtask

    // Returns cycles until Host_Ack (0 on timeout) and whether the ack was exactly one cycle wide.
    task automatic host_access(input logic wr, input logic [7:0] addr, input logic [63:0] wdata,
                               output logic [63:0] rdata, output int lat, output logic one_wide);
        bus.Host_Req = 1; bus.Host_WrEn = wr; bus.Host_Addr = addr; bus.Host_WrData = wdata;
        lat = 0;
        while (!bus.Host_Ack && lat < 50) begin
            step();
            lat++;
        end
        if (!bus.Host_Ack) lat = 0;
        rdata = bus.Host_RdData;
        bus.Host_Req = 0;
        step();
        one_wide = !bus.Host_Ack;
        $display("host %s addr=%02h data=%016h lat=%0d", wr ? "write" : "read ", addr, wr ? wdata : rdata, lat);
    endtask

    task automatic test_reset();
        int cnt;
        logic [63:0] rd;
        int lat;
        logic one;
        idle_inputs();
        rst = 1;
        step(); step();
        n_checks += 6;
        if (bus.Data_In !== 64'h0)     begin n_fail++; $display("FAIL reset_data_in got=%h exp=0", bus.Data_In); end
        if (bus.Host_RdData !== 64'h0) begin n_fail++; $display("FAIL reset_host_rd got=%h exp=0", bus.Host_RdData); end
        if (bus.Host_Ack !== 1'b0)     begin n_fail++; $display("FAIL reset_ack got=%b exp=0", bus.Host_Ack); end
        if (bus.Init_Done !== 1'b0)    begin n_fail++; $display("FAIL reset_init_done got=%b exp=0", bus.Init_Done); end
        if (bus.Rd_Count !== 16'h0 || bus.Wr_Count !== 16'h0) begin
            n_fail++; $display("FAIL reset_counts got rd=%h wr=%h exp 0/0", bus.Rd_Count, bus.Wr_Count);
        end
        if (sbus.Init_Done !== 1'b1)   begin n_fail++; $display("FAIL reset_noclear_done got=%b exp=1", sbus.Init_Done); end
        rst = 0;
        cnt = 0;
        while (!bus.Init_Done && cnt < 400) begin
            step();
            cnt++;
        end
        n_checks++;
        if (cnt != 256) begin n_fail++; $display("FAIL init_cycles got=%0d exp=256", cnt); end
        $display("init sweep done after %0d cycles", cnt);
        host_access(1'b0, 8'hA5, 64'h0, rd, lat, one);
        n_checks += 3;
        if (rd !== 64'h0) begin n_fail++; $display("FAIL host_rd_a5 got=%h exp=0", rd); end
        if (lat != 1)     begin n_fail++; $display("FAIL host_rd_lat got=%0d exp=1", lat); end
        if (!one)         begin n_fail++; $display("FAIL host_rd_ack_width got=wide exp=1 cycle"); end
    endtask

    task automatic test_cpu_rw();
        logic [63:0] rd;
        cpu_write(8'h10, 64'h0123456789ABCDEF);
        cpu_read(8'h10, rd);
        n_checks += 3;
        if (rd !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL cpu_rd_10 got=%h exp=0123456789abcdef", rd); end
        if (bus.Wr_Count !== 16'd1) begin n_fail++; $display("FAIL wr_count1 got=%0d exp=1", bus.Wr_Count); end
        if (bus.Rd_Count !== 16'd1) begin n_fail++; $display("FAIL rd_count1 got=%0d exp=1", bus.Rd_Count); end
        cpu_write(8'h11, 64'hFFFF0000FFFF0000);
        n_checks++;
        if (bus.Data_In !== 64'h0123456789ABCDEF) begin
            n_fail++; $display("FAIL data_in_hold_on_write got=%h exp=0123456789abcdef", bus.Data_In);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_q [4] = '{64'hA0, 64'hA1A1, 64'hA2A2A2, 64'hA3A3A3A3};
        for (int i = 0; i < 4; i++) begin
            bus.DmemEn = 1; bus.DmemWrEn = 1; bus.Mem_Addr = 8'h40 + 8'(i); bus.Data_Out = exp_q[i];
            step();
        end
        for (int i = 0; i < 4; i++) begin
            bus.DmemEn = 1; bus.DmemWrEn = 0; bus.Mem_Addr = 8'h40 + 8'(i);
            step();
            $display("b2b read addr=%02h data=%016h", 8'h40 + 8'(i), bus.Data_In);
            n_checks++;
            if (bus.Data_In !== exp_q[i]) begin n_fail++; $display("FAIL b2b_rd%0d got=%h exp=%h", i, bus.Data_In, exp_q[i]); end
        end
        bus.DmemEn = 0;
        n_checks++;
        if (bus.Wr_Count !== 16'd6 || bus.Rd_Count !== 16'd5) begin
            n_fail++; $display("FAIL b2b_counts got rd=%0d wr=%0d exp rd=5 wr=6", bus.Rd_Count, bus.Wr_Count);
        end
    endtask

    task automatic test_host_priority();
        cpu_write(8'h20, 64'h2020202000000001);
        bus.Host_Req = 1; bus.Host_WrEn = 0; bus.Host_Addr = 8'h20;
        bus.DmemEn = 1; bus.DmemWrEn = 0; bus.Mem_Addr = 8'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.Host_Ack !== 1'b0) begin n_fail++; $display("FAIL prio_no_ack%0d got=%b exp=0", i, bus.Host_Ack); end
        end
        bus.DmemEn = 0;
        step();
        $display("host read behind cpu: ack=%b data=%016h", bus.Host_Ack, bus.Host_RdData);
        n_checks += 3;
        if (bus.Host_Ack !== 1'b1) begin n_fail++; $display("FAIL prio_ack got=%b exp=1", bus.Host_Ack); end
        if (bus.Host_RdData !== 64'h2020202000000001) begin
            n_fail++; $display("FAIL prio_rdata got=%h exp=2020202000000001", bus.Host_RdData);
        end
        if (bus.Data_In !== 64'h0123456789ABCDEF) begin
            n_fail++; $display("FAIL prio_cpu_data got=%h exp=0123456789abcdef", bus.Data_In);
        end
        bus.Host_Req = 0;
        step();
        n_checks += 2;
        if (bus.Host_Ack !== 1'b0) begin n_fail++; $display("FAIL prio_ack_width got=%b exp=0", bus.Host_Ack); end
        if (bus.Rd_Count !== 16'd8) begin n_fail++; $display("FAIL prio_rd_count got=%0d exp=8", bus.Rd_Count); end
    endtask

    task automatic test_host_write();
        logic [63:0] rd;
        int lat;
        logic one;
        host_access(1'b1, 8'hFF, 64'hDEADBEEF, rd, lat, one);
        n_checks += 5;
        if (lat != 1) begin n_fail++; $display("FAIL host_wr_lat got=%0d exp=1", lat); end
        if (!one)     begin n_fail++; $display("FAIL host_wr_ack_width got=wide exp=1 cycle"); end
        if (rd !== 64'h2020202000000001) begin n_fail++; $display("FAIL host_rdata_hold got=%h exp=2020202000000001", rd); end
        if (bus.Data_In !== 64'h0123456789ABCDEF) begin
            n_fail++; $display("FAIL data_in_host_indep got=%h exp=0123456789abcdef", bus.Data_In);
        end
        if (bus.Wr_Count !== 16'd7) begin n_fail++; $display("FAIL host_wr_not_counted got=%0d exp=7", bus.Wr_Count); end
        cpu_read(8'hFF, rd);
        n_checks++;
        if (rd !== 64'h00000000DEADBEEF) begin n_fail++; $display("FAIL cpu_rd_ff got=%h exp=00000000deadbeef", rd); end
    endtask

    // Small instance has CNT_W=2: after 2 writes the count sits at max-1, then 3 more must stop at max.
    task automatic test_saturation();
        logic [1:0] exp_w [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            sbus.DmemEn = 1; sbus.DmemWrEn = 1; sbus.Mem_Addr = 4'(i); sbus.Data_Out = 8'h30 + 8'(i);
            step();
            $display("small write #%0d wr_count=%0d", i, sbus.Wr_Count);
            n_checks++;
            if (sbus.Wr_Count !== exp_w[i]) begin n_fail++; $display("FAIL wr_sat%0d got=%0d exp=%0d", i, sbus.Wr_Count, exp_w[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            sbus.DmemEn = 1; sbus.DmemWrEn = 0; sbus.Mem_Addr = 4'(i);
            step();
        end
        sbus.DmemEn = 0;
        n_checks += 2;
        if (sbus.Rd_Count !== 2'd3) begin n_fail++; $display("FAIL rd_sat got=%0d exp=3", sbus.Rd_Count); end
        if (sbus.Data_In !== 8'h34) begin n_fail++; $display("FAIL small_rd got=%h exp=34", sbus.Data_In); end
    endtask

    task automatic test_init_ignore();
        int cnt;
        int acks;
        logic [63:0] rd;
        cpu_write(8'h05, 64'h55);
        // Host read is requested in the very cycle reset hits; it must be dropped silently and then stay pending.
        bus.Host_Req = 1; bus.Host_WrEn = 0; bus.Host_Addr = 8'h05;
        rst = 1;
        step();
        rst = 0;
        n_checks++;
        if (bus.Host_Ack !== 1'b0) begin n_fail++; $display("FAIL abort_ack got=%b exp=0", bus.Host_Ack); end
        acks = 0;
        bus.DmemEn = 1; bus.DmemWrEn = 1; bus.Mem_Addr = 8'h05; bus.Data_Out = 64'd7;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.Host_Ack) acks++;
        end
        bus.DmemEn = 0;
        n_checks += 2;
        if (bus.Wr_Count !== 16'd0) begin n_fail++; $display("FAIL init_wr_count got=%0d exp=0", bus.Wr_Count); end
        if (bus.Data_In !== 64'h0)  begin n_fail++; $display("FAIL init_data_in got=%h exp=0", bus.Data_In); end
        rst = 1;
        step();
        rst = 0;
        cnt = 0;
        while (!bus.Init_Done && cnt < 400) begin
            bus.DmemEn = (cnt >= 10 && cnt < 20);
            bus.DmemWrEn = 1;
            step();
            cnt++;
            if (bus.Host_Ack) acks++;
        end
        bus.DmemEn = 0; bus.DmemWrEn = 0;
        $display("restarted sweep done after %0d cycles, acks during init=%0d", cnt, acks);
        n_checks += 2;
        if (cnt != 256) begin n_fail++; $display("FAIL reinit_cycles got=%0d exp=256", cnt); end
        if (acks != 0)  begin n_fail++; $display("FAIL init_acks got=%0d exp=0", acks); end
        step();
        n_checks += 2;
        if (bus.Host_Ack !== 1'b1) begin n_fail++; $display("FAIL pending_host_ack got=%b exp=1", bus.Host_Ack); end
        if (bus.Host_RdData !== 64'h0) begin n_fail++; $display("FAIL pending_host_rd got=%h exp=0", bus.Host_RdData); end
        bus.Host_Req = 0;
        step();
        cpu_read(8'h05, rd);
        n_checks += 2;
        if (rd !== 64'h0) begin n_fail++; $display("FAIL init_ignored_rd05 got=%h exp=0", rd); end
        if (bus.Wr_Count !== 16'd0 || bus.Rd_Count !== 16'd1) begin
            n_fail++; $display("FAIL post_init_counts got rd=%0d wr=%0d exp rd=1 wr=0", bus.Rd_Count, bus.Wr_Count);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_back_to_back();
        test_host_priority();
        test_host_write();
        test_saturation();
        test_init_ignore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
